seg_dynamic_scan: RTL and testbench

SEG_DYNAMIC_SCAN -- requirements
Module: seg_dynamic_scan

---
 rtl/seg_dynamic_scan.sv | 118 +++++++++++
 tb/tb_seg_dynamic_scan.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seg_dynamic_scan.sv
// Multiplexed N-digit 7-segment scanner: per-digit dwell with leading blank window,
// frame-synchronous (tear-free) display update and optional leading-zero suppression.
module seg_dynamic_scan #(
  parameter int DIGITS       = 6,
  parameter int CNT_SCAN_MAX = 49_999,
  parameter int BLANK_CYC    = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     point_in,
  input  logic                  data_vld,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CW = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   data_in_p, pend_data, disp_data;
  logic [DIGITS-1:0]        pend_pt, disp_pt, lz_blank;
  logic                     cnt_last, idx_last, frame_bnd, in_blank;
  logic [3:0]               cur_nib;
  logic                     cur_pt, cur_blank;

  assign data_in_p = data_in;
  assign cnt_last  = (cnt == CW'(CNT_SCAN_MAX));
  assign idx_last  = (idx == IW'(DIGITS - 1));
  assign frame_bnd = en & cnt_last & idx_last;
  assign in_blank  = (cnt < CW'(BLANK_CYC));

  assign cur_nib   = disp_data[idx];
  assign cur_pt    = disp_pt[idx];
  assign cur_blank = lz_blank[idx];

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // A digit is suppressed when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (disp_data[k] == 4'h0);
      lz_blank[k] = lz_en & zero_above;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_pt    <= '0;
      disp_data  <= '0;
      disp_pt    <= '0;
      sel        <= '0;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        cnt <= cnt_last ? '0 : cnt + CW'(1);
        if (cnt_last)
          idx <= idx_last ? '0 : idx + IW'(1);
      end

      if (data_vld) begin
        pend_data <= data_in_p;
        pend_pt   <= point_in;
      end

      // A strobe landing on the boundary bypasses pending so it shows next frame.
      if (frame_bnd) begin
        disp_data <= data_vld ? data_in_p : pend_data;
        disp_pt   <= data_vld ? point_in  : pend_pt;
      end

      frame_done <= frame_bnd;

      if (!en) begin
        sel <= '0;
        seg <= 8'hFF;
      end else begin
        sel <= DIGITS'(1) << idx;
        if (in_blank)
          seg <= 8'hFF;
        else
          seg <= {~cur_pt, cur_blank ? 7'h7F : seg_decode(cur_nib)};
      end
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Scoreboard bench for seg_dynamic_scan (4 digits, 10-cycle dwell, 2-cycle blank):
// expected per-cycle sel/seg/frame_done are queued up front, a monitor pops and compares.
module tb_seg_dynamic_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst, en, data_vld, lz_en;
  logic [15:0] data_in;
  logic [3:0]  point_in;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  seg_dynamic_scan #(.DIGITS(4), .CNT_SCAN_MAX(9), .BLANK_CYC(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .data_in   (data_in),
    .point_in  (point_in),
    .data_vld  (data_vld),
    .lz_en     (lz_en),
    .sel       (sel),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int c, input logic [3:0] s, input logic [7:0] g, input logic f);
    exp_t e;
    e.cyc = c; e.sel = s; e.seg = g; e.fd = f;
    q.push_back(e);
  endtask

  task automatic idle(input int c);
    push(c, 4'b0000, 8'hFF, 1'b0);
  endtask

  // segs = {digit3, digit2, digit1, digit0} hand-decoded seg bytes.
  task automatic push_pos(input int c, input int t, input logic [31:0] segs);
    int d;
    d = (t / 10) % 4;
    push(c, 4'(1 << d), ((t % 10) < 2) ? 8'hFF : segs[8*d +: 8], (t % 40) == 39);
  endtask

  task automatic push_frame(input int base, input logic [31:0] segs);
    for (int t = 0; t < 40; t++) push_pos(base + t, t, segs);
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  always @(negedge sys_clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      checks++;
      if (m.cyc != cyc) begin
        failures++;
        $display("FAIL missed_check exp_cyc=%0d now=%0d", m.cyc, cyc);
      end else if (sel !== m.sel || seg !== m.seg || frame_done !== m.fd) begin
        failures++;
        $display("FAIL scan cyc=%0d got sel=%b seg=%h fd=%b exp sel=%b seg=%h fd=%b",
                 cyc, sel, seg, frame_done, m.sel, m.seg, m.fd);
      end
    end
  end

  initial begin
    sys_rst = 1'b1; en = 1'b0; data_vld = 1'b0; lz_en = 1'b0;
    data_in = 16'h0; point_in = 4'h0;

    // ---- expectations ----
    for (int c = 1; c <= 3; c++) idle(c);                 // in reset
    push_frame(4,   {8'hC0, 8'hC0, 8'hC0, 8'hC0});         // zeros after reset
    push_frame(44,  {8'hF9, 8'h88, 8'hB0, 8'h8E});         // 1A3F, no tearing
    push_frame(84,  {8'hFF, 8'hFF, 8'hFF, 8'h92});         // boundary strobe 0005, lz
    push_frame(124, {8'hFF, 8'h7F, 8'hFF, 8'h78});         // 0007, points on 0 and 2
    for (int t = 0; t < 15; t++) push_pos(164 + t, t, {8'hFF, 8'hB0, 8'hC0, 8'hC0});
    for (int c = 179; c <= 183; c++) idle(c);             // en=0 at cnt=5 of digit 1
    for (int t = 15; t < 40; t++) push_pos(169 + t, t, {8'hFF, 8'hB0, 8'hC0, 8'hC0});
    for (int t = 0; t < 23; t++) push_pos(209 + t, t, {8'hFF, 8'hFF, 8'h99, 8'hA4});
    for (int c = 232; c <= 234; c++) idle(c);             // mid-frame reset
    push_frame(235, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    push_frame(275, {8'hFF, 8'hFF, 8'hFF, 8'hC0});         // pending cleared too

    // ---- stimulus ----
    at_neg(3);   sys_rst = 1'b0; en = 1'b1;
    at_neg(18);  data_vld = 1'b1; data_in = 16'h1A3F; point_in = 4'b0000;
    at_neg(19);  data_vld = 1'b0;
    at_neg(48);  data_vld = 1'b1; data_in = 16'h2222;
    at_neg(49);  data_vld = 1'b0;
    at_neg(82);  data_vld = 1'b1; data_in = 16'h0005;     // lands on frame boundary
    at_neg(83);  data_vld = 1'b0; lz_en = 1'b1;
    at_neg(103); data_vld = 1'b1; data_in = 16'h0007; point_in = 4'b0101;
    at_neg(104); data_vld = 1'b0;
    at_neg(140); data_vld = 1'b1; data_in = 16'h0300; point_in = 4'b0000;
    at_neg(141); data_vld = 1'b0;
    at_neg(178); en = 1'b0;
    at_neg(180); data_vld = 1'b1; data_in = 16'h0042;
    at_neg(181); data_vld = 1'b0;
    at_neg(183); en = 1'b1;
    at_neg(231); sys_rst = 1'b1;
    at_neg(232); data_vld = 1'b1; data_in = 16'hFFFF; point_in = 4'hF;
    at_neg(233); data_vld = 1'b0; point_in = 4'h0;
    at_neg(234); sys_rst = 1'b0;
    at_neg(316);

    while (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      failures++;
      $display("FAIL unchecked exp_cyc=%0d now=%0d", m.cyc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
